// File: rtl/seg_scan_if.sv
// Display-update and scan bundle for the six-digit multiplexed 7-segment controller.
// The master side offers digit updates; the slave side drives the scan outputs.
interface seg_scan_if;
    logic [23:0] digits_in;
    logic        upd_valid;
    logic        upd_ready;
    logic        lzb_en;
    logic [3:0]  num;
    logic [5:0]  an;
    logic [2:0]  digit_idx;
    logic        frame_tick;

    modport master (
        output digits_in, upd_valid, lzb_en,
        input  upd_ready, num, an, digit_idx, frame_tick
    );

    modport slave (
        input  digits_in, upd_valid, lzb_en,
        output upd_ready, num, an, digit_idx, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Six-digit common-anode scan controller: each slot is a blank gap followed by the digit,
// and new digit sets are double-buffered so they only appear at a frame boundary.
module seg_scan_ctrl #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    seg_scan_if.slave  bus
);
    localparam int             CW         = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [5:0]    an_r;
    logic [3:0]    num_r;
    logic          tick_r;
    logic [23:0]   active;
    logic [23:0]   pending;
    logic          pending_full;
    logic          accept;
    logic          wrap_copy;

    // Digit code for a slot; digit5 zero is suppressed when leading-zero blanking is on.
    function automatic logic [3:0] show_code(input logic [23:0] d, input logic [2:0] i,
                                             input logic lzb);
        logic [3:0] c;
        case (i)
            3'd0:    c = d[3:0];
            3'd1:    c = d[7:4];
            3'd2:    c = d[11:8];
            3'd3:    c = d[15:12];
            3'd4:    c = d[19:16];
            3'd5:    c = d[23:20];
            default: c = 4'hF;
        endcase
        if (i == 3'd5 && lzb && c == 4'h0)
            c = 4'hF;
        return c;
    endfunction

    function automatic logic [5:0] anode(input logic [2:0] i);
        logic [5:0] a;
        case (i)
            3'd0:    a = 6'b111110;
            3'd1:    a = 6'b111101;
            3'd2:    a = 6'b111011;
            3'd3:    a = 6'b110111;
            3'd4:    a = 6'b101111;
            3'd5:    a = 6'b011111;
            default: a = 6'b111111;
        endcase
        return a;
    endfunction

    assign accept    = bus.upd_valid && !pending_full;
    assign wrap_copy = (state == SHOW) && (cnt == CNT_LAST) && (idx == 3'd5) && pending_full;

    assign bus.upd_ready  = !pending_full;
    assign bus.an         = an_r;
    assign bus.num        = num_r;
    assign bus.digit_idx  = idx;
    assign bus.frame_tick = tick_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BLANK;
            cnt          <= '0;
            idx          <= 3'd0;
            an_r         <= 6'b111111;
            num_r        <= 4'hF;
            tick_r       <= 1'b0;
            pending_full <= 1'b0;
            active       <= 24'hFFFFFF;
        end else begin
            tick_r <= 1'b0;
            case (state)
                BLANK: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                        an_r  <= anode(idx);
                        num_r <= show_code(active, idx, bus.lzb_en);
                    end
                end
                SHOW: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= BLANK;
                        an_r  <= 6'b111111;
                        num_r <= 4'hF;
                        if (idx == 3'd5) begin
                            idx    <= 3'd0;
                            tick_r <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt   <= cnt + 1'b1;
                        num_r <= show_code(active, idx, bus.lzb_en);
                    end
                end
                default: state <= BLANK;
            endcase

            // A copy needs pending_full, an accept needs it clear, so they never collide.
            if (wrap_copy) begin
                active       <= pending;
                pending_full <= 1'b0;
            end else if (accept) begin
                pending_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            pending <= bus.digits_in;
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a cycle-count reference model.
module tb_seg_scan_ctrl;
    localparam int CD = 8;
    localparam int BC = 2;
    localparam int FR = 6 * CD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    seg_scan_if bus ();

    seg_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          t        = 0;
    bit          m_live   = 1'b0;
    logic [23:0] m_active = 24'hFFFFFF;
    logic [23:0] m_pending = 24'h0;
    bit          m_pfull  = 1'b0;
    logic        lzb_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h want=%0h", tag, t, obs, exp);
        end
    endtask

    // Compare outputs of the current cycle, then advance one clock and update the model.
    task automatic step();
        int         slot;
        int         pos;
        logic [3:0] d;
        logic [5:0] e_an;
        logic [3:0] e_num;
        bit         acc;
        if (m_live) begin
            slot = (t / CD) % 6;
            pos  = t % CD;
            d    = 4'((m_active >> (4 * slot)) & 24'hF);
            if (pos < BC) begin
                e_an  = 6'b111111;
                e_num = 4'hF;
            end else begin
                e_an  = ~(6'd1 << slot);
                e_num = (slot == 5 && lzb_prev && d == 4'h0) ? 4'hF : d;
            end
            chk("an", 32'(bus.an), 32'(e_an));
            chk("num", 32'(bus.num), 32'(e_num));
            chk("digit_idx", 32'(bus.digit_idx), 32'(slot));
            chk("frame_tick", 32'(bus.frame_tick), 32'(t > 0 && t % FR == 0));
            chk("upd_ready", 32'(bus.upd_ready), 32'(!m_pfull));
        end
        @(posedge clk);
        if (rst) begin
            t        = 0;
            m_active = 24'hFFFFFF;
            m_pfull  = 1'b0;
            m_live   = 1'b1;
        end else if (m_live) begin
            acc = bus.upd_valid && !m_pfull;
            t++;
            if (t % FR == 0 && m_pfull) begin
                m_active = m_pending;
                m_pfull  = 1'b0;
            end else if (acc) begin
                m_pending = bus.digits_in;
                m_pfull   = 1'b1;
            end
        end
        lzb_prev = bus.lzb_en;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bit found;
        bus.digits_in = 24'h0;
        bus.upd_valid = 1'b0;
        bus.lzb_en    = 1'b0;
        #1;
        step();
        do_reset();

        // Idle display after reset: blank digits, first tick at 48.
        repeat (60) step();

        // Single update at cycle 3, then a second update held while pending is full.
        do_reset();
        repeat (170) begin
            if (t == 3) begin
                bus.upd_valid = 1'b1;
                bus.digits_in = 24'h123456;
            end else if (t >= 10 && t <= 48) begin
                bus.upd_valid = 1'b1;
                bus.digits_in = 24'h000000;
            end else begin
                bus.upd_valid = 1'b0;
            end
            bus.lzb_en = (t >= 100);
            step();
        end

        // Leading-zero blanking on digit5 with 012345, then turned off.
        do_reset();
        repeat (200) begin
            bus.upd_valid = (t == 0);
            bus.digits_in = 24'h012345;
            bus.lzb_en    = (t < 150);
            step();
        end

        // Random traffic, including A..F codes and frequent zero in digit5.
        repeat (500) begin
            bus.upd_valid = ($urandom % 6 == 0);
            bus.digits_in = 24'($urandom);
            if ($urandom % 2 == 1) bus.digits_in[23:20] = 4'h0;
            bus.lzb_en = ($urandom % 4 != 0);
            step();
        end

        // Reset during digit3 SHOW with an update pending.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if ((t / CD) % 6 == 3 && t % CD >= BC && m_pfull) begin
                found = 1'b1;
            end else begin
                bus.upd_valid = !m_pfull;
                bus.digits_in = 24'($urandom);
                step();
            end
        end
        chk("reach_d3_show_pending", 32'(found), 32'd1);
        bus.upd_valid = 1'b0;
        do_reset();
        chk("post_rst_an", 32'(bus.an), 32'h3F);
        chk("post_rst_num", 32'(bus.num), 32'hF);
        chk("post_rst_idx", 32'(bus.digit_idx), 32'd0);
        chk("post_rst_ready", 32'(bus.upd_ready), 32'd1);
        repeat (100) begin
            bus.lzb_en = ($urandom % 2 == 1);
            step();
        end
        repeat (150) begin
            bus.upd_valid = ($urandom % 5 == 0);
            bus.digits_in = 24'($urandom);
            bus.lzb_en    = ($urandom % 2 == 1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
